// File: rtl/logic_unit_serial_pkg.sv
// Shared definitions for the serial logic unit:
// logic opcodes and FSM state encoding.
package logic_unit_serial_pkg;

  localparam logic [2:0] LOGIC_AND  = 3'b000;
  localparam logic [2:0] LOGIC_OR   = 3'b001;
  localparam logic [2:0] LOGIC_NOR  = 3'b010;
  localparam logic [2:0] LOGIC_NAND = 3'b011;
  localparam logic [2:0] LOGIC_XOR  = 3'b100;
  localparam logic [2:0] LOGIC_XNOR = 3'b101;
  localparam logic [2:0] LOGIC_NOT  = 3'b110;
  localparam logic [2:0] LOGIC_BUF  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/logic_unit_serial_slice.sv
// logic_slice: combinational SLICE_WIDTH-bit logic op from gate primitives.
// Ports: OPR opcode, A_s/B_s slice operands, Y_s slice result.
import logic_unit_serial_pkg::*;

module logic_slice #(
  parameter int SLICE_WIDTH = 4
) (
  input  logic [2:0]             OPR,
  input  logic [SLICE_WIDTH-1:0] A_s,
  input  logic [SLICE_WIDTH-1:0] B_s,
  output logic [SLICE_WIDTH-1:0] Y_s
);

  logic [SLICE_WIDTH-1:0] and_w;
  logic [SLICE_WIDTH-1:0] or_w;
  logic [SLICE_WIDTH-1:0] nor_w;
  logic [SLICE_WIDTH-1:0] nand_w;
  logic [SLICE_WIDTH-1:0] xor_w;
  logic [SLICE_WIDTH-1:0] xnor_w;
  logic [SLICE_WIDTH-1:0] not_w;
  logic [SLICE_WIDTH-1:0] buf_w;

  for (genvar i = 0; i < SLICE_WIDTH; i++) begin : g_bit
    and  u_and  (and_w[i],  A_s[i], B_s[i]);
    or   u_or   (or_w[i],   A_s[i], B_s[i]);
    nor  u_nor  (nor_w[i],  A_s[i], B_s[i]);
    nand u_nand (nand_w[i], A_s[i], B_s[i]);
    xor  u_xor  (xor_w[i],  A_s[i], B_s[i]);
    xnor u_xnor (xnor_w[i], A_s[i], B_s[i]);
    not  u_not  (not_w[i],  A_s[i]);
    buf  u_buf  (buf_w[i],  A_s[i]);
  end

  always_comb begin
    Y_s = '0;
    unique case (OPR)
      LOGIC_AND:  Y_s = and_w;
      LOGIC_OR:   Y_s = or_w;
      LOGIC_NOR:  Y_s = nor_w;
      LOGIC_NAND: Y_s = nand_w;
      LOGIC_XOR:  Y_s = xor_w;
      LOGIC_XNOR: Y_s = xnor_w;
      LOGIC_NOT:  Y_s = not_w;
      LOGIC_BUF:  Y_s = buf_w;
    endcase
  end

endmodule

// File: rtl/logic_unit_serial.sv
// Multi-cycle logic unit: one SLICE_WIDTH slice per clock, START/DONE.
// Ports: CLK, RST(async low), START, OPR, A, B -> BUSY, DONE, Y, ZERO, PARITY.
import logic_unit_serial_pkg::*;

module logic_unit_serial #(
  parameter int DATA_WIDTH  = 32,
  parameter int SLICE_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [2:0]            OPR,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [DATA_WIDTH-1:0] Y,
  output logic                  ZERO,
  output logic                  PARITY
);

  localparam int DW     = DATA_WIDTH;
  localparam int SW     = SLICE_WIDTH;
  localparam int NSLICE = DW / SW;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  if ((DATA_WIDTH % SLICE_WIDTH) != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of SLICE_WIDTH");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      opr_q, opr_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [DW-1:0]   res_q, res_d;
  logic            nz_q, nz_d;
  logic            par_q, par_d;
  logic [DW-1:0]   y_q, y_d;
  logic            zero_q, zero_d;
  logic            parity_q, parity_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  logic [SW-1:0]    slice_y;
  logic [DW+SW-1:0] res_ext;

  // Operand regs shift right, so the current slice is always bits [SW-1:0].
  logic_slice #(
    .SLICE_WIDTH(SW)
  ) u_slice (
    .OPR (opr_q),
    .A_s (a_q[SW-1:0]),
    .B_s (b_q[SW-1:0]),
    .Y_s (slice_y)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opr_d    = opr_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    nz_d     = nz_q;
    par_d    = par_q;
    y_d      = y_q;
    zero_d   = zero_q;
    parity_d = parity_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    // New slice enters at the top; after NSLICE steps slice 0 is at the bottom.
    res_ext  = {slice_y, res_q} >> SW;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        if (START) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
          opr_d   = OPR;
          a_d     = A;
          b_d     = B;
          cnt_d   = '0;
          nz_d    = 1'b0;
          par_d   = 1'b0;
        end
      end
      ST_RUN: begin
        a_d   = a_q >> SW;
        b_d   = b_q >> SW;
        res_d = res_ext[DW-1:0];
        nz_d  = nz_q | (|slice_y);
        par_d = par_q ^ (^slice_y);
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d    = '0;
          y_d      = res_ext[DW-1:0];
          zero_d   = ~nz_d;
          parity_d = par_d;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      opr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      nz_q     <= 1'b0;
      par_q    <= 1'b0;
      y_q      <= '0;
      zero_q   <= 1'b1;
      parity_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opr_q    <= opr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      nz_q     <= nz_d;
      par_q    <= par_d;
      y_q      <= y_d;
      zero_q   <= zero_d;
      parity_q <= parity_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign Y      = y_q;
  assign ZERO   = zero_q;
  assign PARITY = parity_q;

endmodule
